pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_generator.sv | 79 +++++++
 tb/tb_pwm_generator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// 16-channel PWM generator: prescaled 8-bit period counter, per-period duty shadow,
// per-channel off / static-on / PWM selection with registered outputs.
module pwm_generator #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  localparam logic [15:0] PRE_LAST = 16'(CLK_DIV - 1);

  logic [15:0] pre_cnt;
  logic        tick;
  logic [7:0]  period_cnt;
  logic        wrap;
  logic        wrap_q;
  logic [7:0]  duty_shadow;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic        level;
  logic [15:0] chan_next;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // With CLK_DIV=1 the prescaler never leaves 0, so tick is high every clock.
  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick && (period_cnt == 8'hFF);

  // NOTE: non-blocking assignments in every clocked block so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt    <= '0;
      period_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
      if (tick) begin
        period_cnt <= period_cnt + 8'd1;
      end
    end
  end

  // Duty is sampled only at the period boundary so mid-period writes cannot distort a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_shadow <= '0;
    end else if (wrap) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    level     = (duty_shadow == 8'hFF) || (period_cnt < duty_shadow);
    chan_next = en_out & (~en_pwm | {16{level}});
  end

  // wrap_q delays the boundary marker so period_start lines up with the first registered
  // output value of the new period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q       <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= '0;
    end else begin
      wrap_q       <= wrap;
      period_start <= wrap_q;
      pwm_out      <= chan_next;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: table vectors, period/duty corner sequences and
// randomized traffic against a time-indexed reference model (CLK_DIV=13 and CLK_DIV=1).
module tb_pwm_generator;

  localparam int DIV0 = 13;
  localparam int DIV1 = 1;
  localparam int P0   = 256 * DIV0;
  localparam int P1   = 256 * DIV1;

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [15:0] exp_out;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;
  logic [15:0] pwm_out, pwm_out1;
  logic        period_start, period_start1;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          k      = 0;   // rising edges since reset release
  logic [7:0]  sh0    = '0;  // model duty in force, CLK_DIV=13 instance
  logic [7:0]  sh1    = '0;  // model duty in force, CLK_DIV=1 instance

  always #5 clk = ~clk;

  pwm_generator #(.CLK_DIV(DIV0)) u_dut (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle(duty), .pwm_out(pwm_out), .period_start(period_start)
  );

  pwm_generator #(.CLK_DIV(DIV1)) u_dut_div1 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle(duty), .pwm_out(pwm_out1), .period_start(period_start1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  // Channel value after k edges: step index = k/div within a 256-step period.
  function automatic logic [15:0] model_out(int kk, int div, logic [7:0] sh);
    int   phase;
    logic lvl;
    phase = (kk / div) % 256;
    lvl   = (sh == 8'd255) || (phase < int'(sh));
    return en_out & (~en_pwm | {16{lvl}});
  endfunction

  // One clock: predict, clock, update model, sample 1 time unit after the edge.
  task automatic step();
    logic [15:0] e0, e1;
    logic        p0, p1;
    if (rst) begin
      e0 = '0; e1 = '0; p0 = 1'b0; p1 = 1'b0;
    end else begin
      e0 = model_out(k, DIV0, sh0);
      e1 = model_out(k, DIV1, sh1);
      p0 = (k > 0) && (k % P0 == 0);
      p1 = (k > 0) && (k % P1 == 0);
    end
    @(posedge clk);
    if (!rst) begin
      if ((k + 1) % P0 == 0) sh0 = duty;
      if ((k + 1) % P1 == 0) sh1 = duty;
      k++;
    end
    #1;
    check("pwm_out", 32'(pwm_out), 32'(e0));
    check("period_start", 32'(period_start), 32'(p0));
    check("pwm_out_div1", 32'(pwm_out1), 32'(e1));
    check("period_start_div1", 32'(period_start1), 32'(p1));
  endtask

  task automatic sync_period();
    int n = 0;
    while (period_start !== 1'b1 && n < 2 * P0) begin
      step();
      n++;
    end
    check("sync_period_start", 32'(period_start), 32'd1);
  endtask

  // Called on a period_start sample; counts bit0 high clocks over one full period and
  // finishes on the next period_start sample.
  task automatic count_period(input int change_at, input logic [7:0] new_duty,
                              output int highs, output logic first);
    highs = int'(pwm_out[0]);
    first = pwm_out[0];
    for (int i = 1; i < P0; i++) begin
      if (i == change_at) duty = new_duty;
      en_out = {15'($urandom), 1'b1};
      en_pwm = {15'($urandom), 1'b1};
      step();
      highs += int'(pwm_out[0]);
    end
    step();
    check("period_length", 32'(period_start), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   h, h3;
    logic f;

    tbl[0] = '{eo: 16'hFFFF, ep: 16'h0000, exp_out: 16'hFFFF};
    tbl[1] = '{eo: 16'h00F0, ep: 16'h0000, exp_out: 16'h00F0};
    tbl[2] = '{eo: 16'hFFFF, ep: 16'hFFFF, exp_out: 16'h0000};
    tbl[3] = '{eo: 16'hA5A5, ep: 16'h0F0F, exp_out: 16'hA0A0};
    tbl[4] = '{eo: 16'h0000, ep: 16'hFFFF, exp_out: 16'h0000};
    tbl[5] = '{eo: 16'h8001, ep: 16'h0001, exp_out: 16'h8000};

    #2;
    check("reset_pwm_out", 32'(pwm_out), 32'h0);
    check("reset_period_start", 32'(period_start), 32'h0);
    en_out = 16'hFFFF;
    repeat (3) step();
    rst  = 1'b0;
    duty = 8'd128;

    // First period after reset: duty shadow is 0, so only static channels show.
    foreach (tbl[i]) begin
      en_out = tbl[i].eo;
      en_pwm = tbl[i].ep;
      step();
      check("table_out", 32'(pwm_out), 32'(tbl[i].exp_out));
      check("table_out_div1", 32'(pwm_out1), 32'(tbl[i].exp_out));
    end

    en_out = 16'h0001;
    en_pwm = 16'h0001;
    sync_period();

    count_period(100, 8'd0, h, f);
    check("duty128_high", 32'(h), 32'd1664);
    count_period(100, 8'd255, h, f);
    check("duty0_high", 32'(h), 32'd0);
    h3 = 0;
    count_period(100, 8'd255, h, f); h3 += h;
    count_period(100, 8'd255, h, f); h3 += h;
    count_period(100, 8'd64, h, f);  h3 += h;
    check("duty255_three_periods", 32'(h3), 32'(3 * P0));
    count_period(1000, 8'd192, h, f);
    check("duty64_midchange_keep", 32'(h), 32'd832);
    count_period(100, 8'd128, h, f);
    check("duty192_next_period", 32'(h), 32'd2496);
    check("duty192_high_at_start", 32'(f), 32'd1);

    // Asynchronous reset mid-period, between clock edges.
    repeat (500) step();
    #2;
    rst = 1'b1;
    k = 0; sh0 = '0; sh1 = '0;
    #1;
    check("async_reset_pwm_out", 32'(pwm_out), 32'h0);
    check("async_reset_period_start", 32'(period_start), 32'h0);
    repeat (2) step();
    rst    = 1'b0;
    en_out = 16'h0003;
    en_pwm = 16'h0001;
    step();
    check("static_on_after_release", 32'(pwm_out[1]), 32'd1);
    h = int'(pwm_out[0]);
    for (int i = 1; i < P0; i++) begin
      step();
      h += int'(pwm_out[0]);
    end
    check("first_period_pwm_low", 32'(h), 32'd0);
    step();
    check("first_load_period_start", 32'(period_start), 32'd1);
    count_period(100, 8'd128, h, f);
    check("first_load_duty128", 32'(h), 32'd1664);

    // Randomized traffic, checked every clock by the model.
    for (int i = 0; i < 4000; i++) begin
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      if ($urandom_range(0, 7) == 0) duty = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
